// File: rtl/flex_queue_if.sv
// Handshake bundle for flex_queue: producer side (in_*) and consumer side (out_*).
// master = producer/consumer environment, slave = the queue.
interface flex_queue_if #(
  parameter int DWIDTH = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DWIDTH-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DWIDTH-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/flex_queue.sv
// Circular-buffer FIFO with any DEPTH >= 2, synchronous flush, almost-full and sticky overflow.
// Optional same-cycle empty-queue bypass enabled by defining FLEX_QUEUE_BYPASS_EN.
module flex_queue #(
  parameter int DWIDTH   = 8,
  parameter int DEPTH    = 9,
  parameter int AF_LEVEL = DEPTH - 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  flex_queue_if.slave                  bus,
  input  logic                         flush,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         almost_full,
  output logic                         ovf_err
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [DWIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     cnt_q;
  logic              run_q;
  logic              stored;
  logic              push;
  logic              pop;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (32'(p) == DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  // run_q keeps in_ready low while reset is held and until the first edge after release
  assign stored       = (cnt_q != '0);
  assign bus.in_ready = run_q && (32'(cnt_q) < DEPTH) && !flush;
  assign pop          = stored && bus.out_ready;
  assign count        = cnt_q;
  assign almost_full  = run_q && (32'(cnt_q) >= AF_LEVEL);

`ifdef FLEX_QUEUE_BYPASS_EN
  logic bypass;

  // Empty queue with a ready consumer: hand the word straight through, storage untouched
  assign bypass        = run_q && !stored && bus.in_valid && bus.out_ready && !flush;
  assign push          = bus.in_valid && bus.in_ready && !bypass;
  assign bus.out_valid = stored || bypass;
  assign bus.out_data  = stored ? mem[rd_ptr] : (bypass ? bus.in_data : '0);
`else
  assign push          = bus.in_valid && bus.in_ready;
  assign bus.out_valid = stored;
  assign bus.out_data  = stored ? mem[rd_ptr] : '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt_q   <= '0;
      run_q   <= 1'b0;
      ovf_err <= 1'b0;
    end else begin
      run_q <= 1'b1;
      // A push dropped by flush is not an overflow
      if (bus.in_valid && !bus.in_ready && !flush)
        ovf_err <= 1'b1;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt_q  <= '0;
      end else begin
        if (push)
          wr_ptr <= ptr_next(wr_ptr);
        if (pop)
          rd_ptr <= ptr_next(rd_ptr);
        case ({push, pop})
          2'b10:   cnt_q <= cnt_q + 1'b1;
          2'b01:   cnt_q <= cnt_q - 1'b1;
          default: cnt_q <= cnt_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= bus.in_data;
  end

endmodule

// File: doc/flex_queue.md
FLEX_QUEUE -- requirements
Module: flex_queue

Interface
REQ-001 The block SHALL have parameter DWIDTH, default 8, meaning the payload width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 9, meaning the entry count; any integer of 2 or more SHALL be legal, including non-power-of-2 values.
REQ-003 The block SHALL have parameter AF_LEVEL, default DEPTH-2, meaning the almost-full threshold in entries.
REQ-004 Port clk: input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-005 Port rst_n: input, 1 bit, reset, asynchronous and active-low.
REQ-006 Port in_valid: input, 1 bit, the producer offers in_data.
REQ-007 Port in_ready: output, 1 bit, the queue accepts this cycle.
REQ-008 Port in_data: input, DWIDTH bits, the producer payload.
REQ-009 Port out_valid: output, 1 bit, out_data is valid.
REQ-010 Port out_ready: input, 1 bit, the consumer accepts this cycle.
REQ-011 Port out_data: output, DWIDTH bits, the head payload.
REQ-012 Port flush: input, 1 bit, a synchronous discard of all entries.
REQ-013 Port count: output, $clog2(DEPTH+1) bits, the current occupancy.
REQ-014 Port almost_full: output, 1 bit, asserted when count >= AF_LEVEL.
REQ-015 Port ovf_err: output, 1 bit, sticky; set when in_valid is high while in_ready is low.

Function
REQ-016 A push SHALL occur on a cycle with in_valid && in_ready; a pop SHALL occur on a cycle with out_valid && out_ready.
REQ-017 in_ready SHALL equal (count < DEPTH) && !flush; a full queue SHALL NOT accept a push even in a cycle that also pops.
REQ-018 out_valid SHALL equal (count > 0), except as extended by REQ-027.
REQ-019 out_data SHALL present the oldest entry, and SHALL stay stable while out_valid && !out_ready.
REQ-020 Without bypass, a push into an empty queue SHALL make out_valid high on the next cycle (latency 1 clk).
REQ-021 Write and read pointers SHALL wrap from DEPTH-1 to 0.
REQ-022 Count update rules:
- push and pop together: count unchanged, FIFO order preserved.
- push only: count +1.
- pop only: count -1.
REQ-023 A flush SHALL zero both pointers and count at the next edge; flush SHALL take priority over a simultaneous push or pop, and any push offered in that cycle SHALL be dropped without setting ovf_err.
REQ-024 almost_full and count SHALL be registered-state derived, with no combinational path from in_valid or out_ready.
REQ-025 ovf_err SHALL clear only on reset; flush SHALL NOT clear it.

Reset
REQ-026 While rst_n is low, the block SHALL hold:
- pointers, count and ovf_err at 0;
- out_valid and almost_full at 0;
- out_data at 0;
- in_ready at 0.
After rst_n deasserts, in_ready SHALL be 1 at the first edge (flush low). Assertion of rst_n mid-transfer SHALL discard all entries immediately.

Configuration
REQ-027 With macro FLEX_QUEUE_BYPASS_EN defined, when count == 0 && in_valid && out_ready && !flush, the block SHALL:
- drive out_valid = 1 and out_data = in_data combinationally in that cycle;
- leave storage unwritten, so count remains 0.
REQ-028 Without FLEX_QUEUE_BYPASS_EN, no combinational path SHALL exist from in_* to out_*, and REQ-020 latency SHALL apply.

Verification
REQ-029 The bench SHALL cover: DEPTH=9, push 0x01..0x09 with out_ready=0 -> count=9, in_ready=0, almost_full high from count=7; then drain -> 0x01..0x09 in order, count=0.
REQ-030 The bench SHALL cover: DEPTH=5, 20 back-to-back cycles with in_valid=out_ready=1 after one prefill -> count steady at 1, pointers wrap, output order equals input order.
REQ-031 The bench SHALL cover: count=4, flush=1 with in_valid=1 and data 0xAA -> next cycle count=0, out_valid=0, 0xAA never appears, ovf_err=0.
REQ-032 The bench SHALL cover: full queue with in_valid=1 held 1 cycle -> ovf_err=1 persists through flush and clears only on rst_n low.
REQ-033 The bench SHALL cover: with BYPASS_EN and an empty queue, in_data=0x5C, in_valid=out_ready=1 -> out_data=0x5C and out_valid=1 the same cycle, count stays 0; without the macro, 0x5C appears one cycle later.
REQ-034 The bench SHALL cover: rst_n pulsed low mid-burst with count=3 -> out_valid=0 and count=0 immediately, without waiting for clk.
